// File: rtl/fetch_instr_queue_pkg.sv
// Shared types for the fetch-to-dispatch instruction queue.
// One queue entry carries an instruction with its PC and predicted next PC.
package fetch_instr_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  typedef struct packed {
    word_t instr;
    pc_t   PC;
    pc_t   nPC;
  } iq_entry_t;

  localparam int unsigned IqDefaultDepth = 4;

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_instr_queue_if.sv
// Fetch-side and dispatch-side signals of the instruction queue.
// The slave modport is the queue itself; the master modport is its environment.
interface fetch_instr_queue_if
  import fetch_instr_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH     = IqDefaultDepth,
  parameter int unsigned LOG_IQ_DEPTH = $clog2(IQ_DEPTH)
);

  word_t                 fetch_instr;
  logic                  fetch_ivalid;
  pc_t                   fetch_PC;
  pc_t                   fetch_nPC;
  logic                  iq_stall_fetch;
  logic                  pipeline_flush;
  logic                  dispatch_ready;
  logic                  dispatch_valid;
  word_t                 dispatch_instr;
  pc_t                   dispatch_PC;
  pc_t                   dispatch_nPC;
  logic [LOG_IQ_DEPTH:0] iq_count;

  modport master (
    output fetch_instr,
    output fetch_ivalid,
    output fetch_PC,
    output fetch_nPC,
    output pipeline_flush,
    output dispatch_ready,
    input  iq_stall_fetch,
    input  dispatch_valid,
    input  dispatch_instr,
    input  dispatch_PC,
    input  dispatch_nPC,
    input  iq_count
  );

  modport slave (
    input  fetch_instr,
    input  fetch_ivalid,
    input  fetch_PC,
    input  fetch_nPC,
    input  pipeline_flush,
    input  dispatch_ready,
    output iq_stall_fetch,
    output dispatch_valid,
    output dispatch_instr,
    output dispatch_PC,
    output dispatch_nPC,
    output iq_count
  );

endinterface

// File: rtl/fetch_instr_queue.sv
// Decoupling FIFO between fetch and dispatch; stalls fetch when full and
// empties on pipeline flush so wrong-path instructions never reach dispatch.
module fetch_instr_queue
  import fetch_instr_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH     = IqDefaultDepth,
  parameter int unsigned LOG_IQ_DEPTH = $clog2(IQ_DEPTH)
) (
  input logic                CLK,
  input logic                nRST,
  fetch_instr_queue_if.slave iq
);

  typedef logic [LOG_IQ_DEPTH-1:0] ptr_t;
  typedef logic [LOG_IQ_DEPTH:0]   cnt_t;

  localparam ptr_t PtrOne  = ptr_t'(1);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam cnt_t CntFull = cnt_t'(IQ_DEPTH);

  if (!is_pow2(IQ_DEPTH) || (IQ_DEPTH < 2)) begin : g_bad_depth
    $error("fetch_instr_queue: IQ_DEPTH must be a power of 2 and at least 2");
  end

  iq_entry_t entries_q [IQ_DEPTH];
  iq_entry_t entries_d [IQ_DEPTH];
  ptr_t      head_q, head_d;
  ptr_t      tail_q, tail_d;
  cnt_t      count_q, count_d;

  logic      full, empty, enq, deq;
  iq_entry_t head_entry;

  always_comb begin
    // Status comes from registered count only, so stall has no input path.
    full  = (count_q == CntFull);
    empty = (count_q == '0);
    enq   = iq.fetch_ivalid & ~full & ~iq.pipeline_flush;
    deq   = ~empty & iq.dispatch_ready & ~iq.pipeline_flush;

    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (iq.pipeline_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        entries_d[tail_q] = '{instr: iq.fetch_instr, PC: iq.fetch_PC, nPC: iq.fetch_nPC};
        tail_d            = tail_q + PtrOne;
      end
      if (deq) begin
        head_d = head_q + PtrOne;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end

    head_entry = empty ? '0 : entries_q[head_q];

    iq.iq_stall_fetch = full;
    iq.dispatch_valid = ~empty;
    iq.dispatch_instr = head_entry.instr;
    iq.dispatch_PC    = head_entry.PC;
    iq.dispatch_nPC   = head_entry.nPC;
    iq.iq_count       = count_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Self-checking bench for fetch_instr_queue: directed vector table, reset
// corner cases, and randomized traffic against a queue-based reference model.
module tb_fetch_instr_queue;
  import fetch_instr_queue_pkg::*;

  localparam int unsigned Depth = 4;

  logic CLK;
  logic nRST;

  fetch_instr_queue_if #(.IQ_DEPTH(Depth)) iq_if ();

  fetch_instr_queue #(.IQ_DEPTH(Depth)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .iq   (iq_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  iq_entry_t model_q[$];

  typedef struct {
    logic  iv;
    word_t instr;
    pc_t   pc;
    logic  flush;
    logic  ready;
    logic  ev;
    word_t einstr;
    pc_t   epc;
    int    ecount;
    logic  estall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input word_t instr, input int pc,
                              input logic flush, input logic ready, input logic ev,
                              input word_t einstr, input int epc, input int ecount,
                              input logic estall);
    vec_t v;
    v.iv     = iv;
    v.instr  = instr;
    v.pc     = pc_t'(pc);
    v.flush  = flush;
    v.ready  = ready;
    v.ev     = ev;
    v.einstr = einstr;
    v.epc    = pc_t'(epc);
    v.ecount = ecount;
    v.estall = estall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    iq_entry_t h;
    h = '0;
    if (model_q.size() != 0) h = model_q[0];
    chk({tag, " valid"}, 32'(iq_if.dispatch_valid), 32'(model_q.size() != 0));
    chk({tag, " instr"}, iq_if.dispatch_instr, h.instr);
    chk({tag, " PC"}, 32'(iq_if.dispatch_PC), 32'(h.PC));
    chk({tag, " nPC"}, 32'(iq_if.dispatch_nPC), 32'(h.nPC));
    chk({tag, " count"}, 32'(iq_if.iq_count), 32'(model_q.size()));
    chk({tag, " stall"}, 32'(iq_if.iq_stall_fetch), 32'(model_q.size() == Depth));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"}, 32'(iq_if.dispatch_valid), 32'd0);
    chk({tag, " instr"}, iq_if.dispatch_instr, 32'd0);
    chk({tag, " PC"}, 32'(iq_if.dispatch_PC), 32'd0);
    chk({tag, " nPC"}, 32'(iq_if.dispatch_nPC), 32'd0);
    chk({tag, " count"}, 32'(iq_if.iq_count), 32'd0);
    chk({tag, " stall"}, 32'(iq_if.iq_stall_fetch), 32'd0);
  endtask

  // Drive one cycle of inputs, advance the reference model, sample 1 after the edge.
  task automatic cycle(input logic iv, input word_t instr, input pc_t pc, input pc_t npc,
                       input logic flush, input logic ready);
    bit full_b;
    bit valid_b;
    iq_if.fetch_ivalid   = iv;
    iq_if.fetch_instr    = instr;
    iq_if.fetch_PC       = pc;
    iq_if.fetch_nPC      = npc;
    iq_if.pipeline_flush = flush;
    iq_if.dispatch_ready = ready;
    @(posedge CLK);
    full_b  = (model_q.size() == Depth);
    valid_b = (model_q.size() != 0);
    if (flush) begin
      model_q.delete();
    end else begin
      if (valid_b && ready) void'(model_q.pop_front());
      if (iv && !full_b) model_q.push_back('{instr: instr, PC: pc, nPC: npc});
    end
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_npc;

    nRST                 = 1'b0;
    iq_if.fetch_ivalid   = 1'b0;
    iq_if.fetch_instr    = '0;
    iq_if.fetch_PC       = '0;
    iq_if.fetch_nPC      = '0;
    iq_if.pipeline_flush = 1'b0;
    iq_if.dispatch_ready = 1'b0;

    // Reset state
    #1;
    check_zero("reset");
    #11;
    nRST = 1'b1;
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check_zero("post_reset_idle");

    // Single pass
    vecs.push_back(mk(1, 32'h2001_0005, 4, 0, 0, 1, 32'h2001_0005, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Fill, blocked 5th write, ordered drain
    for (int p = 0; p < 4; p++)
      vecs.push_back(mk(1, 32'hA000_0000 + word_t'(p), p, 0, 0, 1, 32'hA000_0000, 0, p + 1,
                        p == 3));
    vecs.push_back(mk(1, 32'hA000_0004, 4, 0, 0, 1, 32'hA000_0000, 0, 4, 1));
    for (int d = 1; d < 4; d++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA000_0000 + word_t'(d), d, 4 - d, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Flush with same-cycle fetch and ready
    for (int p = 0; p < 3; p++)
      vecs.push_back(mk(1, 32'hC000_0010 + word_t'(p), 16 + p, 0, 0, 1, 32'hC000_0010, 16,
                        p + 1, 0));
    vecs.push_back(mk(1, 32'hC000_0013, 19, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0020, 32, 0, 0, 1, 32'hC000_0020, 32, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Steady state through pointer wrap
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 32'hB000_0000 + word_t'(k), k, 0, 1, 1, 32'hB000_0000 + word_t'(k),
                        k, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cycle(v.iv, v.instr, v.pc, pc_t'(v.pc + 14'd1), v.flush, v.ready);
      exp_npc = v.ev ? 32'(pc_t'(v.epc + 14'd1)) : 32'd0;
      chk($sformatf("vec%0d valid", i), 32'(iq_if.dispatch_valid), 32'(v.ev));
      chk($sformatf("vec%0d instr", i), iq_if.dispatch_instr, v.einstr);
      chk($sformatf("vec%0d PC", i), 32'(iq_if.dispatch_PC), 32'(v.epc));
      chk($sformatf("vec%0d nPC", i), 32'(iq_if.dispatch_nPC), exp_npc);
      chk($sformatf("vec%0d count", i), 32'(iq_if.iq_count), 32'(v.ecount));
      chk($sformatf("vec%0d stall", i), 32'(iq_if.iq_stall_fetch), 32'(v.estall));
      check_model($sformatf("vec%0d model", i));
    end

    // Async reset mid-stream
    cycle(1'b1, 32'hD000_0030, 14'h30, 14'h31, 1'b0, 1'b0);
    cycle(1'b1, 32'hD000_0031, 14'h31, 14'h32, 1'b0, 1'b0);
    check_model("pre_async_reset");
    iq_if.fetch_ivalid = 1'b0;
    #3;
    nRST = 1'b0;
    #1;
    check_zero("async_reset");
    model_q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check_model("after_async_reset");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic iv;
      logic rdy;
      logic fl;
      pc_t  pc;
      iv  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      fl  = ($urandom_range(0, 24) == 0);
      pc  = pc_t'($urandom);
      cycle(iv, word_t'($urandom), pc, pc_t'($urandom), fl, rdy);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
